// File: rtl/drops_sequencer.sv
// drops_sequencer: phase scheduler for the drops game.
// Runs input, paced action and display stages with watchdog and game-over.
module drops_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int TIMEOUT  = 255,
  parameter int FRAME_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               d_inp_i,
  input  logic               d_act_i,
  input  logic               d_disp_i,
  input  logic               dead_i,
  input  logic               restart_i,
  output logic               e_inp_o,
  output logic               e_act_o,
  output logic               e_disp_o,
  output logic               game_over_o,
  output logic               timeout_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic [2:0]         phase_o
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RF_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INP  = 3'd1,
    S_ACT  = 3'd2,
    S_DISP = 3'd3,
    S_OVER = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             r_target;
  logic [WD_W-1:0]    r_wd;
  logic [RF_W-1:0]    r_ref;
  logic               r_step_due;
  logic [FRAME_W-1:0] r_frame;
  logic               r_e_inp;
  logic               r_e_act;
  logic               r_e_disp;
  logic               r_go;
  logic               r_to;
  logic               r_seen;

  logic w_done;
  logic w_stage;
  logic w_acc;
  logic w_exp;
  logic w_fin;

  always_comb begin
    w_done  = 1'b0;
    w_stage = 1'b0;
    unique case (r_state)
      S_INP:   begin w_done = d_inp_i;  w_stage = 1'b1; end
      S_ACT:   begin w_done = d_act_i;  w_stage = 1'b1; end
      S_DISP:  begin w_done = d_disp_i; w_stage = 1'b1; end
      default: ;
    endcase
  end

  // r_wd is zero exactly in the first enabled cycle, so it also masks done
  assign w_acc = w_stage & w_done & (r_wd != '0);
  assign w_exp = w_stage & ~w_acc & (r_wd == WD_W'(TIMEOUT - 1));
  assign w_fin = w_acc | w_exp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_target   <= S_IDLE;
      r_wd       <= '0;
      r_ref      <= '0;
      r_step_due <= 1'b0;
      r_frame    <= '0;
      r_e_inp    <= 1'b0;
      r_e_act    <= 1'b0;
      r_e_disp   <= 1'b0;
      r_go       <= 1'b0;
      r_to       <= 1'b0;
      r_seen     <= 1'b0;
    end else begin
      r_to <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_state  <= S_GAP;
          r_target <= S_INP;
        end
        S_GAP: begin
          r_state  <= r_target;
          r_wd     <= '0;
          r_e_inp  <= (r_target == S_INP);
          r_e_act  <= (r_target == S_ACT);
          r_e_disp <= (r_target == S_DISP);
        end
        S_INP: begin
          if (w_fin) begin
            r_state  <= S_GAP;
            r_target <= r_step_due ? S_ACT : S_DISP;
            r_e_inp  <= 1'b0;
            r_to     <= w_exp;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_ACT: begin
          if (w_fin) begin
            r_e_act <= 1'b0;
            r_to    <= w_exp;
            if (w_acc) begin
              r_frame    <= r_frame + 1'b1;
              r_step_due <= 1'b0;
            end
            if (w_acc && dead_i) begin
              r_state  <= S_OVER;
              r_e_disp <= 1'b1;
              r_go     <= 1'b1;
              r_seen   <= 1'b0;
            end else begin
              r_state  <= S_GAP;
              r_target <= S_DISP;
            end
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DISP: begin
          if (w_fin) begin
            r_state  <= S_GAP;
            r_target <= S_INP;
            r_e_disp <= 1'b0;
            r_to     <= w_exp;
            if (r_ref == RF_W'(TICK_DIV - 1)) begin
              r_ref      <= '0;
              r_step_due <= 1'b1;
            end else begin
              r_ref <= r_ref + 1'b1;
            end
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_OVER: begin
          if (restart_i) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_ref      <= '0;
            r_step_due <= 1'b0;
            r_go       <= 1'b0;
            r_e_disp   <= 1'b0;
            r_seen     <= 1'b0;
          end else if (!r_e_disp) begin
            r_e_disp <= 1'b1;
            r_seen   <= 1'b0;
          end else if (r_seen && d_disp_i) begin
            r_e_disp <= 1'b0;
            r_seen   <= 1'b0;
          end else begin
            r_seen <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign e_inp_o     = r_e_inp;
  assign e_act_o     = r_e_act;
  assign e_disp_o    = r_e_disp;
  assign game_over_o = r_go;
  assign timeout_o   = r_to;
  assign frame_cnt_o = r_frame;
  assign phase_o     = r_state;

endmodule

// File: tb/tb_drops_sequencer.sv
// tb_drops_sequencer: scoreboard bench for drops_sequencer.
// Expected per-cycle outputs are queued; a monitor compares each cycle.
module tb_drops_sequencer;

  typedef struct packed {
    logic [2:0] ph;
    logic       ei;
    logic       ea;
    logic       ed;
    logic       go;
    logic       to;
    logic [3:0] fr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_inp = 1'b0;
  logic       d_act = 1'b0;
  logic       d_disp = 1'b0;
  logic       dead = 1'b0;
  logic       restart = 1'b0;
  logic       e_inp, e_act, e_disp, go, to;
  logic [3:0] frame;
  logic [2:0] phase;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  bit   mon_on = 1'b0;
  int   idx = 0;
  string scn = "none";

  int lat_i = 1, lat_a = 1, lat_d = 1;
  bit hold = 1'b0;
  int k_i = 0, k_a = 0, k_d = 0;

  drops_sequencer #(.TICK_DIV(3), .TIMEOUT(8), .FRAME_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .d_inp_i(d_inp), .d_act_i(d_act), .d_disp_i(d_disp),
    .dead_i(dead), .restart_i(restart),
    .e_inp_o(e_inp), .e_act_o(e_act), .e_disp_o(e_disp),
    .game_over_o(go), .timeout_o(to),
    .frame_cnt_o(frame), .phase_o(phase)
  );

  always #5 clk = ~clk;

  function automatic exp_t snap();
    return {phase, e_inp, e_act, e_disp, go, to, frame};
  endfunction

  // Done responders: done rises once the enable has been high lat cycles
  initial forever begin
    @(posedge clk); #2;
    k_i = e_inp ? k_i + 1 : 0;
    k_a = e_act ? k_a + 1 : 0;
    k_d = e_disp ? k_d + 1 : 0;
    d_inp  = hold | (lat_i != 0 && k_i >= lat_i);
    d_act  = hold | (lat_a != 0 && k_a >= lat_a);
    d_disp = hold | (lat_d != 0 && k_d >= lat_d);
  end

  initial forever begin
    exp_t e, g;
    @(posedge clk); #1;
    if (mon_on && q.size() > 0) begin
      e = q.pop_front();
      g = snap();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s[%0d] got ph=%0d ei=%b ea=%b ed=%b go=%b to=%b fr=%0d want ph=%0d ei=%b ea=%b ed=%b go=%b to=%b fr=%0d",
          scn, idx, g.ph, g.ei, g.ea, g.ed, g.go, g.to, g.fr,
          e.ph, e.ei, e.ea, e.ed, e.go, e.to, e.fr);
      end
      idx++;
    end
  end

  task automatic push_x(int n, int ph, bit ed, bit g, bit t, int fr);
    exp_t e;
    e.ph = 3'(ph);
    e.ei = (ph == 1);
    e.ea = (ph == 2);
    e.ed = ed;
    e.go = g;
    e.to = t;
    e.fr = 4'(fr);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic push(int n, int ph, int fr);
    push_x(n, ph, (ph == 3), 1'b0, 1'b0, fr);
  endtask

  task automatic loop2(int fr);
    push(2, 1, fr); push(1, 5, fr); push(2, 3, fr); push(1, 5, fr);
  endtask

  task automatic begin_scn(string name);
    @(negedge clk);
    mon_on = 1'b0;
    rst = 1'b1;
    restart = 1'b0;
    dead = 1'b0;
    q.delete();
    scn = name;
    idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push(1, 0, 0);
  endtask

  task automatic go_scn();
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_scn();
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d left want 0", scn, q.size());
    end
    mon_on = 1'b0;
  endtask

  initial begin
    begin_scn("pace");
    lat_i = 3; lat_a = 3; lat_d = 3; hold = 1'b0;
    push(1, 5, 0);
    for (int l = 0; l < 3; l++) begin
      push(3, 1, 0); push(1, 5, 0); push(3, 3, 0); push(1, 5, 0);
    end
    push(3, 1, 0); push(1, 5, 0); push(3, 2, 0); push(1, 5, 1);
    push(3, 3, 1); push(1, 5, 1);
    go_scn();
    end_scn();

    begin_scn("over");
    lat_i = 1; lat_a = 1; lat_d = 1;
    dead = 1'b1;
    push(1, 5, 0);
    for (int l = 0; l < 3; l++) loop2(0);
    push(2, 1, 0); push(1, 5, 0); push(2, 2, 0);
    push_x(2, 4, 1'b1, 1'b1, 1'b0, 1);
    push_x(1, 4, 1'b0, 1'b1, 1'b0, 1);
    push_x(2, 4, 1'b1, 1'b1, 1'b0, 1);
    push(1, 0, 0); push(1, 5, 0); loop2(0);
    go_scn();
    repeat (29) @(posedge clk);
    #3 restart = 1'b1;
    @(posedge clk);
    #3 restart = 1'b0;
    end_scn();

    begin_scn("wdog");
    lat_i = 1; lat_a = 0; lat_d = 0;
    push(1, 5, 0);
    for (int l = 0; l < 3; l++) begin
      push(2, 1, 0); push(1, 5, 0); push(8, 3, 0);
      push_x(1, 5, 1'b0, 1'b0, 1'b1, 0);
    end
    push(2, 1, 0); push(1, 5, 0); push(8, 2, 0);
    push_x(1, 5, 1'b0, 1'b0, 1'b1, 0);
    push(8, 3, 0); push_x(1, 5, 1'b0, 1'b0, 1'b1, 0);
    push(2, 1, 0); push(1, 5, 0); push(8, 2, 0);
    push_x(1, 5, 1'b0, 1'b0, 1'b1, 0);
    go_scn();
    end_scn();

    begin_scn("edge");
    lat_i = 1; lat_a = 1; lat_d = 8;
    push(1, 5, 0);
    for (int l = 0; l < 3; l++) begin
      push(2, 1, 0); push(1, 5, 0); push(8, 3, 0); push(1, 5, 0);
    end
    push(2, 1, 0); push(1, 5, 0); push(2, 2, 0); push(1, 5, 1);
    go_scn();
    end_scn();

    begin_scn("wrap");
    lat_i = 1; lat_a = 1; lat_d = 1; hold = 1'b1;
    push(1, 5, 0);
    for (int l = 0; l < 3; l++) loop2(0);
    for (int s = 1; s <= 16; s++) begin
      push(2, 1, s - 1); push(1, 5, s - 1); push(2, 2, s - 1);
      push(1, 5, s % 16); push(2, 3, s % 16); push(1, 5, s % 16);
      loop2(s % 16); loop2(s % 16);
    end
    push(2, 1, 0); push(1, 5, 0); push(1, 2, 0);
    go_scn();
    repeat (359) @(posedge clk);
    end_scn();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (snap() !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL async_rst got ph=%0d ei=%b ea=%b ed=%b want all 0",
        phase, e_inp, e_act, e_disp);
    end
    hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
